d8_pipeline_ctrl: RTL and testbench
===================================

D8_PIPELINE_CTRL -- requirements
Module: d8_pipeline_ctrl

Interface
REQ-001 Parameter: STALL_MAX, default 15, saturation value of the consecutive-stall counter (1..15).
REQ-002 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  decode stage holds a valid instruction.
REQ-005 id_b_rd, id_c_rd  in  1 each  decode instruction reads operand b / c as a register.
REQ-006 id_b, id_c  in  8 each  decode source register indices.
REQ-007 ex_wr, wb_wr  in  1 each  execute / writeback instruction writes a register.
REQ-008 ex_dst, wb_dst  in  8 each  execute / writeback destination register indices.
REQ-009 mem_busy  in  1  memory not ready; whole pipeline must freeze.
REQ-010 br_taken  in  1  execute stage resolved a taken branch.
REQ-011 en_if, en_id, en_ex, en_wb  out  1 each  enables for the four pipeline registers.
REQ-012 flush_id  out  1  clears the IF/ID register to zero (NOP).
REQ-013 nop_ex  out  1  selects op=0, a=b=c=0 into the ID/EX register (bubble).
REQ-014 fwd_b, fwd_c  out  2 each  forward select: 00 none, 01 from EX, 10 from WB.
REQ-015 state  out  2  current FSM state; stall_cnt  out  4; stall_ovf  out  1.

Function
REQ-016 FSM states: RUN=00, HAZ=01, MEM=10, FLUSH=11; state is registered, all enable/flush/nop/fwd outputs are combinational from inputs and state (zero latency).
REQ-017 Hazard: id_valid and state!=FLUSH and ((id_b_rd and b matches) or (id_c_rd and c matches)); a match is idx==ex_dst with ex_wr, or idx==wb_dst with wb_wr; index 0 is not special.
REQ-018 Priority per cycle: mem_busy > br_taken > hazard > none.
REQ-019 mem_busy=1: all en=0, flush_id=0, nop_ex=0; next state MEM.
REQ-020 br_taken=1 (mem_busy=0): all en=1, flush_id=1, nop_ex=1; next state FLUSH.
REQ-021 Hazard (no mem_busy, no br_taken): en_if=en_id=0, en_ex=en_wb=1, nop_ex=1; next state HAZ.
REQ-022 None of the above: all en=1, flush_id=0, nop_ex=0; next state RUN.
REQ-023 FLUSH lasts exactly one cycle unless re-entered; hazard detection is suppressed in FLUSH.
REQ-024 mem_busy and br_taken together: freeze wins; br_taken stays asserted (EX frozen) and is serviced on the first non-busy cycle.
REQ-025 stall_cnt increments on each cycle whose next state is HAZ or MEM, saturates at STALL_MAX, clears to 0 on any other cycle; stall_ovf=1 while stall_cnt==STALL_MAX.

Reset
REQ-026 sys_rst=1 asynchronously forces state=RUN, stall_cnt=0, stall_ovf=0.
REQ-027 While sys_rst=1: all en=0, flush_id=1, nop_ex=1, fwd_b=fwd_c=00, regardless of inputs.
REQ-028 Reset asserted mid-stall or mid-flush aborts it; first cycle after release is evaluated from RUN.

Configuration
REQ-029 Macro D8_PIPELINE_CTRL_FWD_EN defined: register matches are resolved by forwarding, not stalling; fwd_x=01 on an EX match, else 10 on a WB match, else 00; EX has priority; REQ-021 then never fires.
REQ-030 Macro undefined: fwd_b=fwd_c=00 constantly and every match stalls per REQ-021.

Verification
REQ-031 id_valid=1, id_b_rd=1, id_b=3, ex_wr=1, ex_dst=3 -> no macro: en_if=en_id=0, nop_ex=1, state HAZ next; with macro: all en=1, fwd_b=01.
REQ-032 mem_busy=1 for 20 cycles -> all en=0, state=MEM, stall_cnt counts to 15 and holds, stall_ovf=1 from 15th cycle; mem_busy=0 -> stall_cnt=0, state=RUN.
REQ-033 br_taken=1 one cycle with hazard present -> flush_id=1, nop_ex=1, all en=1; next cycle state=FLUSH, hazard ignored, then RUN.
REQ-034 mem_busy=1 and br_taken=1 together, then mem_busy=0 -> freeze first, then flush cycle, then FLUSH state.
REQ-035 sys_rst pulse asynchronously between clock edges during HAZ -> state=RUN and stall_cnt=0 immediately, outputs forced per REQ-027.

Source files
------------

// File: rtl/d8_pipeline_ctrl.sv
// d8_pipeline_ctrl: hazard, stall, flush and forwarding control for a 4-stage IF/ID/EX/WB pipeline.
// Latency: enables, flush, nop and forward selects are combinational from inputs and registered state (0 cycles).
// Backpressure: mem_busy freezes every stage; define D8_PIPELINE_CTRL_FWD_EN to forward register matches instead of stalling.
module d8_pipeline_ctrl #(
    parameter int STALL_MAX = 15
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       id_valid,
    input  logic       id_b_rd,
    input  logic       id_c_rd,
    input  logic [7:0] id_b,
    input  logic [7:0] id_c,
    input  logic       ex_wr,
    input  logic       wb_wr,
    input  logic [7:0] ex_dst,
    input  logic [7:0] wb_dst,
    input  logic       mem_busy,
    input  logic       br_taken,
    output logic       en_if,
    output logic       en_id,
    output logic       en_ex,
    output logic       en_wb,
    output logic       flush_id,
    output logic       nop_ex,
    output logic [1:0] fwd_b,
    output logic [1:0] fwd_c,
    output logic [1:0] state,
    output logic [3:0] stall_cnt,
    output logic       stall_ovf
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HAZ   = 2'b01,
        MEM   = 2'b10,
        FLUSH = 2'b11
    } state_t;

    localparam logic [3:0] CNT_SAT = 4'(STALL_MAX);

    state_t     cur_st;
    state_t     nxt_st;
    logic [3:0] cnt_nxt;
    logic       b_ex;
    logic       b_wb;
    logic       c_ex;
    logic       c_wb;
    logic       b_dep;
    logic       c_dep;
    logic       hazard;
    logic [1:0] fwd_b_sel;
    logic [1:0] fwd_c_sel;

    // Register index 0 is an ordinary register here; no zero-register exemption.
    assign b_ex  = ex_wr && (id_b == ex_dst);
    assign b_wb  = wb_wr && (id_b == wb_dst);
    assign c_ex  = ex_wr && (id_c == ex_dst);
    assign c_wb  = wb_wr && (id_c == wb_dst);
    assign b_dep = id_valid && id_b_rd && (b_ex || b_wb);
    assign c_dep = id_valid && id_c_rd && (c_ex || c_wb);

`ifdef D8_PIPELINE_CTRL_FWD_EN
    // The younger EX result wins over WB when both write the same register.
    assign hazard    = 1'b0;
    assign fwd_b_sel = !b_dep ? 2'b00 : (b_ex ? 2'b01 : 2'b10);
    assign fwd_c_sel = !c_dep ? 2'b00 : (c_ex ? 2'b01 : 2'b10);
`else
    assign hazard    = (cur_st != FLUSH) && (b_dep || c_dep);
    assign fwd_b_sel = 2'b00;
    assign fwd_c_sel = 2'b00;
`endif

    always_comb begin
        en_if    = 1'b1;
        en_id    = 1'b1;
        en_ex    = 1'b1;
        en_wb    = 1'b1;
        flush_id = 1'b0;
        nop_ex   = 1'b0;
        fwd_b    = fwd_b_sel;
        fwd_c    = fwd_c_sel;
        nxt_st   = RUN;
        if (sys_rst) begin
            en_if    = 1'b0;
            en_id    = 1'b0;
            en_ex    = 1'b0;
            en_wb    = 1'b0;
            flush_id = 1'b1;
            nop_ex   = 1'b1;
            fwd_b    = 2'b00;
            fwd_c    = 2'b00;
        end else if (mem_busy) begin
            // A pending branch stays frozen in EX and is serviced once memory frees up.
            en_if  = 1'b0;
            en_id  = 1'b0;
            en_ex  = 1'b0;
            en_wb  = 1'b0;
            nxt_st = MEM;
        end else if (br_taken) begin
            flush_id = 1'b1;
            nop_ex   = 1'b1;
            nxt_st   = FLUSH;
        end else if (hazard) begin
            en_if  = 1'b0;
            en_id  = 1'b0;
            nop_ex = 1'b1;
            nxt_st = HAZ;
        end
    end

    always_comb begin
        cnt_nxt = 4'd0;
        if ((nxt_st == HAZ) || (nxt_st == MEM)) begin
            cnt_nxt = (stall_cnt >= CNT_SAT) ? CNT_SAT : stall_cnt + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cur_st    <= RUN;
            stall_cnt <= 4'd0;
            stall_ovf <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            stall_cnt <= cnt_nxt;
            stall_ovf <= (cnt_nxt == CNT_SAT);
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_d8_pipeline_ctrl.sv
// Bench for d8_pipeline_ctrl: directed vectors, literal spot checks and a per-cycle behavioural model.
module tb_d8_pipeline_ctrl;

    localparam int STALL_MAX = 15;
`ifdef D8_PIPELINE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       id_valid, id_b_rd, id_c_rd;
    logic [7:0] id_b, id_c;
    logic       ex_wr, wb_wr;
    logic [7:0] ex_dst, wb_dst;
    logic       mem_busy, br_taken;
    logic       en_if, en_id, en_ex, en_wb, flush_id, nop_ex;
    logic [1:0] fwd_b, fwd_c, state;
    logic [3:0] stall_cnt;
    logic       stall_ovf;

    int n_checks = 0;
    int n_err    = 0;

    d8_pipeline_ctrl #(.STALL_MAX(STALL_MAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_valid(id_valid), .id_b_rd(id_b_rd), .id_c_rd(id_c_rd),
        .id_b(id_b), .id_c(id_c),
        .ex_wr(ex_wr), .wb_wr(wb_wr), .ex_dst(ex_dst), .wb_dst(wb_dst),
        .mem_busy(mem_busy), .br_taken(br_taken),
        .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_wb(en_wb),
        .flush_id(flush_id), .nop_ex(nop_ex),
        .fwd_b(fwd_b), .fwd_c(fwd_c), .state(state),
        .stall_cnt(stall_cnt), .stall_ovf(stall_ovf)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the pipeline did last cycle, and how many consecutive stalled cycles so far.
    typedef enum {GO, STALL, FREEZE, SQUASH} act_t;
    act_t m_prev = GO;
    int   m_run  = 0;

    function automatic bit reads_pending(input logic rd, input logic [7:0] idx);
        return id_valid && rd && ((ex_wr && idx == ex_dst) || (wb_wr && idx == wb_dst));
    endfunction

    function automatic logic [1:0] fwd_pick(input logic rd, input logic [7:0] idx);
        if (!FWD || !id_valid || !rd) return 2'b00;
        if (ex_wr && idx == ex_dst) return 2'b01;
        if (wb_wr && idx == wb_dst) return 2'b10;
        return 2'b00;
    endfunction

    function automatic act_t classify();
        if (mem_busy) return FREEZE;
        if (br_taken) return SQUASH;
        if (!FWD && m_prev != SQUASH && (reads_pending(id_b_rd, id_b) || reads_pending(id_c_rd, id_c)))
            return STALL;
        return GO;
    endfunction

    function automatic logic [16:0] model_out();
        logic [3:0] en;
        logic       fl, nop, ovf;
        logic [1:0] st;
        logic [3:0] cnt;
        if (sys_rst) return {4'b0000, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0};
        case (m_prev)
            STALL:   st = 2'b01;
            FREEZE:  st = 2'b10;
            SQUASH:  st = 2'b11;
            default: st = 2'b00;
        endcase
        cnt = (m_run >= STALL_MAX) ? 4'(STALL_MAX) : 4'(m_run);
        ovf = (m_run >= STALL_MAX);
        case (classify())
            FREEZE:  begin en = 4'b0000; fl = 1'b0; nop = 1'b0; end
            SQUASH:  begin en = 4'b1111; fl = 1'b1; nop = 1'b1; end
            STALL:   begin en = 4'b0011; fl = 1'b0; nop = 1'b1; end
            default: begin en = 4'b1111; fl = 1'b0; nop = 1'b0; end
        endcase
        return {en, fl, nop, fwd_pick(id_b_rd, id_b), fwd_pick(id_c_rd, id_c), st, cnt, ovf};
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_prev <= GO;
            m_run  <= 0;
        end else begin
            m_prev <= classify();
            m_run  <= (classify() == STALL || classify() == FREEZE) ? m_run + 1 : 0;
        end
    end

    always @(negedge sys_clk) begin
        check("cycle", {en_if, en_id, en_ex, en_wb, flush_id, nop_ex, fwd_b, fwd_c, state, stall_cnt, stall_ovf},
              model_out());
    end

    function automatic logic [3:0] ens();
        return {en_if, en_id, en_ex, en_wb};
    endfunction

    task automatic idle();
        id_valid = 0; id_b_rd = 0; id_c_rd = 0; id_b = 0; id_c = 0;
        ex_wr = 0; wb_wr = 0; ex_dst = 0; wb_dst = 0; mem_busy = 0; br_taken = 0;
    endtask

    task automatic haz_b3();
        id_valid = 1; id_b_rd = 1; id_b = 8'd3; ex_wr = 1; ex_dst = 8'd3;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    initial begin
        // Reset dominates even with every request asserted.
        idle(); mem_busy = 1; br_taken = 1; haz_b3();
        #3;
        check("rst_en", ens(), 4'h0);
        check("rst_flush", flush_id, 1);
        check("rst_nop", nop_ex, 1);
        check("rst_fwd", {fwd_b, fwd_c}, 0);
        check("rst_state", state, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_ovf", stall_ovf, 0);
        tick(); tick();
        sys_rst = 0; idle(); #1;
        check("run_en", ens(), 4'hF);
        check("run_nop", nop_ex, 0);
        tick();
        check("run_state", state, 0);

        // EX match on b.
        haz_b3(); #1;
        check("exb_en", ens(), FWD ? 4'hF : 4'h3);
        check("exb_nop", nop_ex, FWD ? 0 : 1);
        check("exb_fwd", fwd_b, FWD ? 1 : 0);
        tick();
        check("exb_state", state, FWD ? 0 : 1);
        check("exb_cnt1", stall_cnt, FWD ? 0 : 1);
        tick();
        check("exb_cnt2", stall_cnt, FWD ? 0 : 2);

        // WB match on c.
        idle(); id_valid = 1; id_c_rd = 1; id_c = 8'd7; wb_wr = 1; wb_dst = 8'd7; #1;
        check("wbc_en", ens(), FWD ? 4'hF : 4'h3);
        check("wbc_fwd", fwd_c, FWD ? 2 : 0);
        tick();
        check("wbc_cnt", stall_cnt, FWD ? 0 : 3);

        // EX and WB both match b: EX forward wins.
        idle(); id_valid = 1; id_b_rd = 1; id_b = 8'd9; ex_wr = 1; ex_dst = 8'd9; wb_wr = 1; wb_dst = 8'd9; #1;
        check("both_fwd", fwd_b, FWD ? 1 : 0);
        tick();

        // Matches that must not stall.
        idle(); haz_b3(); id_valid = 0; #1;
        check("novalid_en", ens(), 4'hF);
        idle(); haz_b3(); id_b_rd = 0; #1;
        check("nord_en", ens(), 4'hF);
        idle(); haz_b3(); ex_wr = 0; #1;
        check("nowr_en", ens(), 4'hF);
        tick();
        check("nohaz_cnt", stall_cnt, 0);

        // Register 0 is tracked like any other.
        idle(); id_valid = 1; id_b_rd = 1; id_b = 8'd0; ex_wr = 1; ex_dst = 8'd0; #1;
        check("reg0_en", ens(), FWD ? 4'hF : 4'h3);
        tick();
        idle(); tick();

        // Long memory freeze: counter saturates at STALL_MAX.
        mem_busy = 1; #1;
        check("mem_en", ens(), 4'h0);
        check("mem_flush", flush_id, 0);
        check("mem_nop", nop_ex, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1)  check("mem_state", state, 2);
            if (i == 14) begin check("mem_cnt14", stall_cnt, 14); check("mem_ovf14", stall_ovf, 0); end
            if (i == 15) begin check("mem_cnt15", stall_cnt, 15); check("mem_ovf15", stall_ovf, 1); end
            if (i == 20) begin check("mem_cnt20", stall_cnt, 15); check("mem_ovf20", stall_ovf, 1); end
        end
        mem_busy = 0; #1;
        check("memend_en", ens(), 4'hF);
        tick();
        check("memend_state", state, 0);
        check("memend_cnt", stall_cnt, 0);
        check("memend_ovf", stall_ovf, 0);

        // Branch with a hazard present: flush, then hazard ignored for the FLUSH cycle.
        haz_b3(); br_taken = 1; #1;
        check("br_flush", flush_id, 1);
        check("br_nop", nop_ex, 1);
        check("br_en", ens(), 4'hF);
        tick();
        check("br_state", state, 3);
        br_taken = 0; #1;
        check("flush_en", ens(), 4'hF);
        check("flush_nop", nop_ex, 0);
        tick();
        check("flush_state", state, 0);
        #1;
        check("postflush_en", ens(), FWD ? 4'hF : 4'h3);
        tick();
        check("postflush_state", state, FWD ? 0 : 1);
        idle(); tick();

        // Freeze with pending branch, branch serviced after memory frees.
        mem_busy = 1; br_taken = 1; #1;
        check("mb_en", ens(), 4'h0);
        check("mb_flush", flush_id, 0);
        tick();
        check("mb_state", state, 2);
        mem_busy = 0; #1;
        check("mb_br_flush", flush_id, 1);
        check("mb_br_en", ens(), 4'hF);
        tick();
        check("mb_br_state", state, 3);
        br_taken = 0; tick();
        check("mb_end_state", state, 0);

        // Asynchronous reset in the middle of a stall.
        haz_b3(); tick(); tick(); tick();
        check("pre_rst_cnt", stall_cnt, FWD ? 0 : 3);
        check("pre_rst_state", state, FWD ? 0 : 1);
        #1 sys_rst = 1;
        #1;
        check("arst_state", state, 0);
        check("arst_cnt", stall_cnt, 0);
        check("arst_en", ens(), 4'h0);
        check("arst_flush", flush_id, 1);
        check("arst_nop", nop_ex, 1);
        tick();
        sys_rst = 0; #1;
        check("rel_en", ens(), FWD ? 4'hF : 4'h3);
        tick();
        check("rel_state", state, FWD ? 0 : 1);
        check("rel_cnt", stall_cnt, FWD ? 0 : 1);

        // Asynchronous reset in the middle of a flush: next evaluation starts from RUN.
        idle(); tick();
        br_taken = 1; tick();
        br_taken = 0; haz_b3(); #1;
        check("mf_suppr_en", ens(), 4'hF);
        #1 sys_rst = 1;
        #2 sys_rst = 0;
        #1;
        check("mf_state", state, 0);
        check("mf_en", ens(), FWD ? 4'hF : 4'h3);
        tick();
        check("mf_next_state", state, FWD ? 0 : 1);
        idle(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
